// File: rtl/store_buffer.sv
// Load/store unit: queues stores in a small FIFO, drains them to the peripheral bus in order, issues loads.
// Latency: store push takes 1 edge; a load takes >= 3 cycles (request, bus read, result pulse) on a zero-wait bus.
// Backpressure: hold_o stalls the pipeline while the FIFO is full or a load is outstanding; prp_ready paces the bus.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    byte_sel,
  input  logic          ld_unsigned,
  input  logic          mem_re,
  input  logic [AW-1:0] mem_raddr,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_waddr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata_o,
  output logic          mem_rvalid_o,
  output logic          hold_o,
  output logic          prp_re_o,
  output logic          prp_we_o,
  output logic [AW-1:0] prp_addr,
  output logic [DW-1:0] prp_wdata,
  output logic [3:0]    prp_wstrb,
  input  logic [DW-1:0] prp_rdata,
  input  logic          prp_ready
);

  // Lane handling below assumes a 32-bit data path with four byte lanes.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

  state_t        state, state_nxt;

  // Store FIFO storage and bookkeeping
  logic [AW-1:0] q_addr [DEPTH];
  logic [DW-1:0] q_data [DEPTH];
  logic [3:0]    q_strb [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [PW-1:0] slot_off [DEPTH];

  logic          full, push, pop;
  logic          ld_hit, ld_ok, ld_start, wr_start;

  // Formatted store entry
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_rep, st_data;
  logic [3:0]    st_strb;

  // Load attributes captured when the bus read is launched
  logic [AW-1:0] ld_waddr;
  logic [1:0]    ld_size, ld_lane;
  logic          ld_uns;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [DW-1:0] ld_result;

  assign full     = (count == CW'(DEPTH));
  assign push     = mem_we & ~full;
  assign pop      = (state == WR) & prp_ready;
  assign ld_waddr = {mem_raddr[AW-1:2], 2'b00};
  assign ld_ok    = mem_re & ~mem_we & ~ld_hit;

  // Loads stall from request until the result cycle; stores stall only on a full FIFO.
  assign hold_o = rst & ((mem_we & full) | (mem_re & ~mem_we & (state != DONE)));

  // Place store data in its byte lanes and clear the lanes it does not enable
  always_comb begin
    st_addr = {mem_waddr[AW-1:2], 2'b00};
    case (byte_sel)
      2'b00: begin
        st_strb = 4'b0001 << mem_waddr[1:0];
        st_rep  = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << {mem_waddr[1], 1'b0};
        st_rep  = {2{mem_wdata[15:0]}};
      end
      default: begin
        st_strb = 4'b1111;
        st_rep  = mem_wdata;
      end
    endcase
    for (int b = 0; b < 4; b++) begin
      st_data[8*b +: 8] = st_rep[8*b +: 8] & {8{st_strb[b]}};
    end
  end

  // A load must not overtake a buffered store to the same word
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off[i] = PW'(i) - rd_ptr;
      if (({1'b0, slot_off[i]} < count) && (q_addr[i] == ld_waddr)) begin
        ld_hit = 1'b1;
      end
    end
  end

  // FIFO payload; contents need no reset because count gates validity
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= st_addr;
      q_data[wr_ptr] <= st_data;
      q_strb[wr_ptr] <= st_strb;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Bus sequencer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state: an eligible load beats draining; one bus access at a time
  always_comb begin
    state_nxt = state;
    ld_start  = 1'b0;
    wr_start  = 1'b0;
    case (state)
      IDLE: begin
        if (ld_ok) begin
          state_nxt = RD;
          ld_start  = 1'b1;
        end else if (count != '0) begin
          state_nxt = WR;
          wr_start  = 1'b1;
        end
      end
      WR:      if (prp_ready) state_nxt = IDLE;
      RD:      if (prp_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pick the addressed lane out of the returned bus word and extend it
  always_comb begin
    case (ld_lane)
      2'd0:    ld_byte = prp_rdata[7:0];
      2'd1:    ld_byte = prp_rdata[15:8];
      2'd2:    ld_byte = prp_rdata[23:16];
      default: ld_byte = prp_rdata[31:24];
    endcase
    ld_half = ld_lane[1] ? prp_rdata[31:16] : prp_rdata[15:0];
    case (ld_size)
      2'b00:   ld_result = {{24{~ld_uns & ld_byte[7]}}, ld_byte};
      2'b01:   ld_result = {{16{~ld_uns & ld_half[15]}}, ld_half};
      default: ld_result = prp_rdata;
    endcase
  end

  // Registered bus and result outputs, loaded as each state is entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prp_we_o     <= 1'b0;
      prp_re_o     <= 1'b0;
      mem_rvalid_o <= 1'b0;
      prp_addr     <= '0;
      prp_wdata    <= '0;
      prp_wstrb    <= '0;
      mem_rdata_o  <= '0;
      ld_size      <= '0;
      ld_lane      <= '0;
      ld_uns       <= 1'b0;
    end else begin
      prp_we_o     <= (state_nxt == WR);
      prp_re_o     <= (state_nxt == RD);
      mem_rvalid_o <= (state_nxt == DONE);
      if (wr_start) begin
        prp_addr  <= q_addr[rd_ptr];
        prp_wdata <= q_data[rd_ptr];
        prp_wstrb <= q_strb[rd_ptr];
      end else if (ld_start) begin
        prp_addr  <= ld_waddr;
        prp_wdata <= '0;
        prp_wstrb <= '0;
        ld_size   <= byte_sel;
        ld_lane   <= mem_raddr[1:0];
        ld_uns    <= ld_unsigned;
      end
      if ((state == RD) && prp_ready) mem_rdata_o <= ld_result;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed protocol scenarios followed by a random store/load mix
// checked against a byte-addressed memory model and an in-order expected bus-write queue.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  byte_sel;
  logic        ld_unsigned, mem_re, mem_we;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata;
  logic [31:0] mem_rdata_o;
  logic        mem_rvalid_o, hold_o, prp_re_o, prp_we_o;
  logic [31:0] prp_addr, prp_wdata, prp_rdata;
  logic [3:0]  prp_wstrb;
  logic        prp_ready;

  int checks = 0;
  int failures = 0;
  bit bus_auto = 1'b0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic [7:0] bus_mem [logic [31:0]];
  logic [7:0] model   [logic [31:0]];
  wr_t        exp_wr  [$];

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .byte_sel(byte_sel), .ld_unsigned(ld_unsigned),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_rdata_o(mem_rdata_o), .mem_rvalid_o(mem_rvalid_o),
    .hold_o(hold_o), .prp_re_o(prp_re_o), .prp_we_o(prp_we_o), .prp_addr(prp_addr),
    .prp_wdata(prp_wdata), .prp_wstrb(prp_wstrb), .prp_rdata(prp_rdata), .prp_ready(prp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[11:4] ^ 8'hA5;
  endfunction

  function automatic int sz(input logic [1:0] sel);
    return (sel == 2'b00) ? 1 : (sel == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [7:0] mrd(input logic [31:0] a);
    if (model.exists(a)) return model[a];
    return init_byte(a);
  endfunction

  function automatic logic [31:0] bus_word(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] ba;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      ba = a + 32'(k);
      w[8*k +: 8] = bus_mem.exists(ba) ? bus_mem[ba] : init_byte(ba);
    end
    return w;
  endfunction

  // Expected load value straight from the byte memory: little-endian, size-aligned, extended
  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sel, input logic uns);
    int s;
    logic [31:0] base, v;
    s = sz(sel);
    base = a & ~32'(s - 1);
    v = '0;
    for (int k = 0; k < s; k++) v = v | (32'(mrd(base + 32'(k))) << (8 * k));
    if (!uns && s < 4 && v[8*s-1]) v = v | ~((32'd1 << (8 * s)) - 32'd1);
    return v;
  endfunction

  // Commit a store to the model in program order and predict its bus write
  task automatic model_store(input logic [31:0] a, input logic [1:0] sel, input logic [31:0] d);
    int s;
    logic [31:0] base, m;
    wr_t e;
    s = sz(sel);
    base = a & ~32'(s - 1);
    m = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
    for (int k = 0; k < s; k++) model[base + 32'(k)] = d[8*k +: 8];
    e.addr = {base[31:2], 2'b00};
    e.data = (d & m) << (8 * base[1:0]);
    e.strb = 4'(((1 << s) - 1) << base[1:0]);
    exp_wr.push_back(e);
  endtask

  task automatic bus_drive();
    prp_ready = ($urandom_range(0, 3) != 0);
    prp_rdata = prp_re_o ? bus_word(prp_addr) : $urandom;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (bus_auto) bus_drive();
  endtask

  // Automatic bus slave: a write completes on the edge after this sample
  always @(negedge clk) begin
    wr_t e;
    if (bus_auto && rst && prp_we_o && prp_ready) begin
      for (int k = 0; k < 4; k++) if (prp_wstrb[k]) bus_mem[prp_addr + 32'(k)] = prp_wdata[8*k +: 8];
      chk("bus_write_expected", 32'(exp_wr.size() != 0), 32'd1);
      if (exp_wr.size() != 0) begin
        e = exp_wr.pop_front();
        chk("bus_write_addr", prp_addr, e.addr);
        chk("bus_write_data", prp_wdata, e.data);
        chk("bus_write_strb", 32'(prp_wstrb), 32'(e.strb));
      end
    end
  end

  // Directed load on a manually driven bus; reports cycles until prp_re_o
  task automatic manual_load(input string tag, input logic [31:0] a, input logic [1:0] sel,
                             input logic uns, input logic [31:0] bdata, input logic [31:0] exp,
                             output int lat);
    int pulses;
    mem_re = 1'b1; mem_raddr = a; byte_sel = sel; ld_unsigned = uns; prp_ready = 1'b0;
    lat = 0;
    while (!prp_re_o && lat < 50) begin
      cyc();
      lat++;
    end
    chk({tag, "_re_seen"}, 32'(prp_re_o), 32'd1);
    chk({tag, "_addr"}, prp_addr, {a[31:2], 2'b00});
    prp_rdata = bdata; prp_ready = 1'b1;
    cyc();
    prp_ready = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_rvalid_o) begin
        pulses++;
        chk({tag, "_data"}, mem_rdata_o, exp);
        mem_re = 1'b0;
      end
      cyc();
    end
    mem_re = 1'b0;
    chk({tag, "_pulses"}, 32'(pulses), 32'd1);
    chk({tag, "_data_held"}, mem_rdata_o, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nwr, seen, op_budget;
    logic [31:0] wa [$];
    logic [31:0] a, d, e;
    logic [1:0]  sel;
    logic        uns, done;

    rst = 1'b0; byte_sel = 2'b00; ld_unsigned = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
    mem_raddr = '0; mem_waddr = '0; mem_wdata = '0; prp_rdata = '0; prp_ready = 1'b0;

    // Reset state
    cyc(); cyc();
    chk("rst_prp_we", 32'(prp_we_o), 32'd0);
    chk("rst_prp_re", 32'(prp_re_o), 32'd0);
    chk("rst_rvalid", 32'(mem_rvalid_o), 32'd0);
    chk("rst_hold", 32'(hold_o), 32'd0);
    chk("rst_addr", prp_addr, 32'd0);
    chk("rst_rdata", mem_rdata_o, 32'd0);
    rst = 1'b1;
    cyc();

    // Byte store to 0x103, then a word load from the same word waits for the drain
    mem_we = 1'b1; byte_sel = 2'b00; mem_waddr = 32'h103; mem_wdata = 32'h1234_56AB;
    #1 chk("t2_store_hold", 32'(hold_o), 32'd0);
    cyc();
    mem_we = 1'b0; mem_re = 1'b1; mem_raddr = 32'h100; byte_sel = 2'b10; ld_unsigned = 1'b0;
    #1 chk("t2_load_hold", 32'(hold_o), 32'd1);
    cyc();
    chk("t2_we", 32'(prp_we_o), 32'd1);
    chk("t2_re_not_first", 32'(prp_re_o), 32'd0);
    chk("t2_waddr", prp_addr, 32'h100);
    chk("t2_wstrb", 32'(prp_wstrb), 32'h8);
    chk("t2_wdata", prp_wdata, 32'hAB00_0000);
    prp_ready = 1'b1;
    cyc();
    prp_ready = 1'b0;
    chk("t2_we_done", 32'(prp_we_o), 32'd0);
    cyc();
    chk("t2_re", 32'(prp_re_o), 32'd1);
    chk("t2_raddr", prp_addr, 32'h100);
    prp_rdata = 32'hAB00_1122; prp_ready = 1'b1;
    cyc();
    chk("t2_rvalid", 32'(mem_rvalid_o), 32'd1);
    chk("t2_rdata", mem_rdata_o, 32'hAB00_1122);
    chk("t2_hold_in_done", 32'(hold_o), 32'd0);
    mem_re = 1'b0; prp_ready = 1'b0;
    cyc();
    chk("t2_rvalid_drop", 32'(mem_rvalid_o), 32'd0);

    // Halfword loads from 0x202 with zero and sign extension
    manual_load("t4_lhu", 32'h202, 2'b01, 1'b1, 32'h8001_1234, 32'h0000_8001, lat);
    chk("t4_latency", 32'(lat), 32'd1);
    manual_load("t4_lh", 32'h202, 2'b01, 1'b0, 32'h8001_1234, 32'hFFFF_8001, lat);

    // Signed byte load from 0x301 slips ahead of the second of two queued stores
    mem_we = 1'b1; byte_sel = 2'b10; mem_waddr = 32'h400; mem_wdata = 32'h1111_1111;
    cyc();
    mem_waddr = 32'h404; mem_wdata = 32'h2222_2222;
    cyc();
    mem_we = 1'b0; mem_re = 1'b1; mem_raddr = 32'h301; byte_sel = 2'b00; ld_unsigned = 1'b0;
    chk("t5_first_write", prp_addr, 32'h400);
    #1 chk("t5_hold", 32'(hold_o), 32'd1);
    prp_ready = 1'b1;
    cyc();
    prp_ready = 1'b0;
    cyc();
    chk("t5_re_first", 32'(prp_re_o), 32'd1);
    chk("t5_we_not_first", 32'(prp_we_o), 32'd0);
    chk("t5_raddr", prp_addr, 32'h300);
    prp_rdata = 32'h0000_F000; prp_ready = 1'b1;
    cyc();
    chk("t5_rvalid", 32'(mem_rvalid_o), 32'd1);
    chk("t5_rdata", mem_rdata_o, 32'hFFFF_FFF0);
    mem_re = 1'b0; prp_ready = 1'b0;
    cyc(); cyc();
    chk("t5_second_we", 32'(prp_we_o), 32'd1);
    chk("t5_second_addr", prp_addr, 32'h404);
    chk("t5_second_data", prp_wdata, 32'h2222_2222);
    prp_ready = 1'b1;
    cyc();
    prp_ready = 1'b0;
    cyc();
    chk("t5_drained", 32'(prp_we_o), 32'd0);

    // Five back-to-back word stores against a stalled bus
    byte_sel = 2'b10;
    for (int i = 0; i < 4; i++) begin
      mem_we = 1'b1; mem_waddr = 32'h500 + 32'(4 * i); mem_wdata = 32'(i + 1);
      #1 chk("t3_push_hold", 32'(hold_o), 32'd0);
      cyc();
    end
    mem_waddr = 32'h510; mem_wdata = 32'd5;
    #1 chk("t3_full_hold", 32'(hold_o), 32'd1);
    cyc();
    chk("t3_full_hold2", 32'(hold_o), 32'd1);
    prp_ready = 1'b1;
    cyc();
    prp_ready = 1'b0;
    #1 chk("t3_hold_release", 32'(hold_o), 32'd0);
    cyc();
    mem_we = 1'b0; prp_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (prp_we_o) wa.push_back(prp_addr);
      cyc();
    end
    prp_ready = 1'b0;
    chk("t3_drain_count", 32'(wa.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain_order", (i < wa.size()) ? wa[i] : 32'hDEAD_DEAD, 32'h504 + 32'(4 * i));
    end

    // Reset while a write is on the bus
    mem_we = 1'b1; mem_waddr = 32'h600; mem_wdata = 32'h6666_6666;
    cyc();
    mem_we = 1'b0;
    cyc();
    chk("t1_we_before", 32'(prp_we_o), 32'd1);
    rst = 1'b0;
    #1;
    chk("t1_we", 32'(prp_we_o), 32'd0);
    chk("t1_addr", prp_addr, 32'd0);
    chk("t1_wdata", prp_wdata, 32'd0);
    chk("t1_wstrb", 32'(prp_wstrb), 32'd0);
    chk("t1_rdata", mem_rdata_o, 32'd0);
    chk("t1_hold", 32'(hold_o), 32'd0);
    cyc();
    rst = 1'b1; prp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (prp_we_o || prp_re_o) seen++;
    end
    chk("t1_no_access_after", 32'(seen), 32'd0);
    prp_ready = 1'b0;

    // Random store/load mix against the memory model
    bus_auto = 1'b1;
    cyc();
    for (int op = 0; op < 250; op++) begin
      a = 32'h1000 + 32'($urandom_range(0, 63));
      sel = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        mem_we = 1'b1; mem_waddr = a; mem_wdata = d; byte_sel = sel;
        mem_re = 1'($urandom_range(0, 1)); mem_raddr = 32'h1000 + 32'($urandom_range(0, 63));
        done = 1'b0;
        for (op_budget = 0; op_budget < 200 && !done; op_budget++) begin
          #1;
          if (!hold_o) done = 1'b1;
          cyc();
        end
        chk("t6_store_accepted", 32'(done), 32'd1);
        if (done) model_store(a, sel, d);
        mem_we = 1'b0; mem_re = 1'b0;
      end else begin
        e = exp_load(a, sel, uns);
        mem_re = 1'b1; mem_raddr = a; byte_sel = sel; ld_unsigned = uns;
        done = 1'b0;
        for (op_budget = 0; op_budget < 300 && !done; op_budget++) begin
          #1;
          if (mem_rvalid_o) begin
            done = 1'b1;
            chk("t6_load_data", mem_rdata_o, e);
          end
          cyc();
        end
        chk("t6_load_completed", 32'(done), 32'd1);
        mem_re = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) cyc();
    end
    nwr = 0;
    while (exp_wr.size() != 0 && nwr < 300) begin
      cyc();
      nwr++;
    end
    chk("t6_all_stores_written", 32'(exp_wr.size()), 32'd0);
    for (int i = 0; i < 5; i++) cyc();
    chk("t6_bus_idle", 32'(prp_we_o | prp_re_o), 32'd0);
    bus_auto = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
